// File: rtl/adc_scan_ctrl.sv
// SPI scan master for ADC128S102-family converters: masked multi-channel scans
// with pipelined addressing, continuous mode and a per-channel result file.
module adc_scan_ctrl #(
  parameter int unsigned N_CH    = 8,
  parameter int unsigned RES     = 12,
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned GAP_CYC = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            abort,
  input  logic            cont,
  input  logic [N_CH-1:0] ch_mask,
  output logic            busy,
  output logic            done,
  output logic            err,
  output logic            res_stb,
  output logic [2:0]      res_ch,
  output logic [RES-1:0]  res_data,
  input  logic [2:0]      rd_ch,
  output logic [RES-1:0]  rd_data,
  output logic [N_CH-1:0] valid,
  output logic            SCLK,
  output logic            CSn,
  output logic            DIN,
  input  logic            DOUT
);

  localparam int unsigned CNT_MAX = (CLK_DIV > GAP_CYC) ? CLK_DIV : GAP_CYC;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX);
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SHIFT,
    S_HOLD,
    S_GAP
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       bit_q, bit_d;
  logic [3:0]       frm_q, frm_d;
  logic [3:0]       m_q, m_d;
  logic [7:0][2:0]  list_q, list_d;
  logic [11:0]      sr_q, sr_d;
  logic             sclk_q, sclk_d;
  logic             csn_q, csn_d;
  logic             din_q, din_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             res_stb_q, res_stb_d;
  logic [2:0]       res_ch_q, res_ch_d;
  logic [RES-1:0]   res_data_q, res_data_d;
  logic [N_CH-1:0]  valid_q, valid_d;
  logic [RES-1:0]   regs_q [8];

  logic [7:0][2:0]  scan_list;
  logic [3:0]       scan_m;
  logic [2:0]       frm_addr;
  logic [2:0]       stb_ch;
  logic [3:0]       bit_nx;
  logic             div_last;

  // Ascending list of enabled channels and its length, from the live mask
  always_comb begin
    scan_list = '0;
    scan_m    = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (ch_mask[i]) begin
        scan_list[scan_m[2:0]] = 3'(i);
        scan_m                 = scan_m + 4'd1;
      end
    end
  end

  // The extra frame after the last channel re-addresses c[0] as a dummy
  assign frm_addr = (frm_q < m_q) ? list_q[frm_q[2:0]] : list_q[0];
  assign stb_ch   = list_q[3'(frm_q - 4'd1)];
  assign bit_nx   = bit_q + 4'd1;
  assign div_last = (cnt_q == DIV_LAST);

  function automatic logic addr_bit(input logic [3:0] b, input logic [2:0] a);
    case (b)
      4'd2:    return a[2];
      4'd3:    return a[1];
      4'd4:    return a[0];
      default: return 1'b0;
    endcase
  endfunction

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    frm_d      = frm_q;
    m_d        = m_q;
    list_d     = list_q;
    sr_d       = sr_q;
    sclk_d     = sclk_q;
    csn_d      = csn_q;
    din_d      = din_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    res_stb_d  = 1'b0;
    res_ch_d   = res_ch_q;
    res_data_d = res_data_q;
    valid_d    = valid_q;

    case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          if (scan_m == 4'd0) begin
            err_d = 1'b1;
          end else begin
            list_d  = scan_list;
            m_d     = scan_m;
            cnt_d   = '0;
            csn_d   = 1'b0;
            sclk_d  = 1'b1;
            din_d   = 1'b0;
            busy_d  = 1'b1;
            state_d = S_SETUP;
          end
        end
      end

      S_SETUP: begin
        if (div_last) begin
          cnt_d   = '0;
          sclk_d  = 1'b0;
          bit_d   = '0;
          frm_d   = '0;
          din_d   = 1'b0;
          state_d = S_SHIFT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_SHIFT: begin
        // First cycle after a frame's last rising edge: data is complete
        if (sclk_q && cnt_q == '0 && bit_q == 4'd15 && frm_q != 4'd0) begin
          res_stb_d  = 1'b1;
          res_ch_d   = stb_ch;
          res_data_d = sr_q[11 -: RES];
          for (int i = 0; i < N_CH; i++) begin
            if (stb_ch == 3'(i)) valid_d[i] = 1'b1;
          end
        end
        if (!div_last) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          cnt_d = '0;
          if (!sclk_q) begin
            sclk_d = 1'b1;
            sr_d   = {sr_q[10:0], DOUT};
          end else if (bit_q != 4'd15) begin
            sclk_d = 1'b0;
            bit_d  = bit_nx;
            din_d  = addr_bit(bit_nx, frm_addr);
          end else if (frm_q == m_q) begin
            state_d = S_HOLD;
          end else begin
            sclk_d = 1'b0;
            bit_d  = '0;
            frm_d  = frm_q + 4'd1;
            din_d  = 1'b0;
          end
        end
      end

      S_HOLD: begin
        if (div_last) begin
          cnt_d   = '0;
          csn_d   = 1'b1;
          din_d   = 1'b0;
          done_d  = 1'b1;
          state_d = cont ? S_GAP : S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d = '0;
          if (scan_m == 4'd0) begin
            err_d   = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
          end else begin
            list_d  = scan_list;
            m_d     = scan_m;
            csn_d   = 1'b0;
            state_d = S_SETUP;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Abort drops the bus at once; a partial frame never reaches the strobe
    if (abort) begin
      state_d   = S_IDLE;
      cnt_d     = '0;
      csn_d     = 1'b1;
      sclk_d    = 1'b1;
      din_d     = 1'b0;
      busy_d    = 1'b0;
      done_d    = 1'b0;
      err_d     = 1'b0;
      res_stb_d = 1'b0;
      valid_d   = valid_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      frm_q      <= '0;
      m_q        <= '0;
      list_q     <= '0;
      sr_q       <= '0;
      sclk_q     <= 1'b1;
      csn_q      <= 1'b1;
      din_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      res_stb_q  <= 1'b0;
      res_ch_q   <= '0;
      res_data_q <= '0;
      valid_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      frm_q      <= frm_d;
      m_q        <= m_d;
      list_q     <= list_d;
      sr_q       <= sr_d;
      sclk_q     <= sclk_d;
      csn_q      <= csn_d;
      din_q      <= din_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      res_stb_q  <= res_stb_d;
      res_ch_q   <= res_ch_d;
      res_data_q <= res_data_d;
      valid_q    <= valid_d;
    end
  end

  // Written at the end of the strobe cycle so a same-cycle read sees the old value
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) regs_q[i] <= '0;
    end else if (res_stb_q) begin
      regs_q[res_ch_q] <= res_data_q;
    end
  end

  assign rd_data  = (32'(rd_ch) < N_CH) ? regs_q[rd_ch] : '0;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;
  assign res_stb  = res_stb_q;
  assign res_ch   = res_ch_q;
  assign res_data = res_data_q;
  assign valid    = valid_q;
  assign SCLK     = sclk_q;
  assign CSn      = csn_q;
  assign DIN      = din_q;

endmodule
